// File: rtl/add_seq_ctrl_pkg.sv
// rtl/add_seq_ctrl_pkg.sv - shared state encoding and slice width for the wide add sequencer
package add_seq_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_seq_ctrl_nibble_fa4.sv
// rtl/add_seq_ctrl_nibble_fa4.sv - combinational 4-bit ripple adder built from full-adder bit equations
module nibble_fa4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic c1;
    logic c2;
    logic c3;

    // Each bit: sum = a ^ b ^ cin, carry = generate | (propagate & cin)
    assign s[0] = a[0] ^ b[0] ^ ci;
    assign c1   = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));
    assign s[1] = a[1] ^ b[1] ^ c1;
    assign c2   = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
    assign s[2] = a[2] ^ b[2] ^ c2;
    assign c3   = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));
    assign s[3] = a[3] ^ b[3] ^ c3;
    assign co   = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));

endmodule

// File: rtl/add_seq_ctrl.sv
// rtl/add_seq_ctrl.sv - start/busy/done sequencer time-sharing one nibble adder across a wide operand
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      sub,
    input  logic [4*NIBBLES-1:0]      a,
    input  logic [4*NIBBLES-1:0]      b,
    output logic                      busy,
    output logic                      done,
    output logic [4*NIBBLES-1:0]      sum,
    output logic                      cout,
    output logic                      ovf
);

    localparam int W    = NIBBLE_W * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [IDXW-1:0] idx;
    logic            carry;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [3:0]      nib_a;
    logic [3:0]      nib_b;
    logic [3:0]      slice_s;
    logic            slice_co;
    logic            last;

    assign last = (idx == IDXW'(NIBBLES - 1));

    // Select the current nibble of each operand; constant-index loop keeps every select in range
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDXW'(i)) begin
                nib_a = op_a[i*NIBBLE_W +: NIBBLE_W];
                nib_b = op_b[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    nibble_fa4 u_slice (
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start is only honoured in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        busy = (state == RUN) || (state == DONE);
        done = (state == DONE);
    end

    // Datapath: latch operands on start, then ripple one nibble per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b here and seed the carry with 1
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx == IDXW'(i)) begin
                            sum[i*NIBBLE_W +: NIBBLE_W] <= slice_s;
                        end
                    end
                    carry <= slice_co;
                    if (last) begin
                        cout <= slice_co;
                        ovf  <= (op_a[W-1] == op_b[W-1]) && (slice_s[3] != op_a[W-1]);
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
Multi-cycle sequencer for wide add/subtract. It time-shares a single 4-bit full-adder slice across NIBBLES nibbles, least-significant first, holding the ripple carry in a register between cycles. It sits between a requester using a start/busy/done handshake and the shared nibble slice. The result is a 4*NIBBLES-bit sum with carry-out and signed-overflow flags.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand (operand width W = 4*NIBBLES); legal range 1..16
IDXW, $clog2(NIBBLES) (minimum 1), width of the nibble index counter; derived, not overridden

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  W  operand A; sampled with start
b  input  W  operand B; sampled with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse when the result is final
sum  output  W  result; holds its value until the next accepted start
cout  output  1  final carry (for sub: 1 means no borrow)
ovf  output  1  two's-complement signed overflow of the result

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy, done, cout, ovf = 0; sum = 0; index and carry registers = 0; operand registers = 0. Reset asserted in any state, including mid-RUN, aborts the operation with no done pulse.
- Clock and reset naming: one clock, clk; one reset, rst, synchronous and active-high.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - latch opA <= a; opB <= sub ? ~b : b; carry <= sub; idx <= 0.
  - clear sum, cout, ovf to 0.
  - next state RUN.
- IDLE, start=0: stay in IDLE; all outputs hold.
- RUN, each cycle:
  - slice inputs: opA[4*idx +: 4], opB[4*idx +: 4], carry.
  - sum[4*idx +: 4] <= slice sum; carry <= slice carry-out.
  - if idx == NIBBLES-1: cout <= slice carry-out; ovf <= (opA[W-1] == opB[W-1]) && (slice sum bit 3 != opA[W-1]); next state DONE.
  - otherwise idx <= idx+1.
- DONE: done=1 for exactly one cycle, busy=1; next state IDLE.
- Latency: start accepted at edge 0 -> done high during cycle NIBBLES+1 -> a new start can be accepted on the following cycle. Throughput is one operation per NIBBLES+2 cycles.
- start while busy (RUN or DONE) is ignored. Changes on a, b or sub while busy have no effect.
- Wrap-around: carry out of the MSB nibble does not feed back; sum wraps modulo 2^W.
- sum, cout and ovf are valid from the done cycle onward and stay stable through IDLE until the next accepted start.
- Partial sum bits are visible during RUN; consumers use sum only on or after done.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the NIBBLE_W=4 constant.
- One sub-module, nibble_fa4: combinational 4-bit ripple adder with ports a[3:0], b[3:0], ci, s[3:0], co, built from per-bit full-adder equations. Exactly one instance.
- The controller holds the FSM, index counter, carry register, operand registers and result registers.

Test Plan:
- NIBBLES=4, add 0x1234 + 0x0FFF -> sum=0x2233, cout=0, ovf=0; done exactly 5 cycles after the start edge, busy high for 5 cycles.
- Add 0xFFFF + 0x0001 -> sum=0x0000, cout=1, ovf=0. Then add 0x7FFF + 0x0001 -> sum=0x8000, cout=0, ovf=1.
- sub=1, 0x0005 - 0x0007 -> sum=0xFFFE, cout=0, ovf=0. Then 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Pulse start again, with a=0x1111, during RUN cycle 2 of 0x0001 + 0x0001 -> ignored; sum=0x0002 with a single done pulse; sum holds 0x0002 for 10 idle cycles.
- Assert rst for one cycle during RUN -> next cycle state=IDLE, busy=0, sum=0, no done pulse. A following start of 3+4 gives sum=0x0007.
- NIBBLES=1 build: 0xF + 0x1 -> sum=0x0, cout=1; done 2 cycles after the start edge. Back-to-back starts, one on the cycle after each done, all complete.
